// File: rtl/tron_pkg.sv
// Shared types for the light-cycle game logic.
// Directions, FSM states, head coordinates, grid defaults, winner codes.
package tron_pkg;

    localparam int COORD_W    = 10;
    localparam int GRID_W_DEF = 800;
    localparam int GRID_H_DEF = 600;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        MOVE,
        Q1,
        Q2,
        Q3,
        RESOLVE,
        OVER
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Opposite directions differ only in bit 1.
    function automatic logic is_reverse(
        input logic [1:0] req,
        input logic [1:0] cur
    );
        return (req ^ cur) == 2'b10;
    endfunction

endpackage

// File: rtl/bike_step.sv
// Combinational one-pixel step of a bike head in a given direction.
// Ports: head/dir in; next (saturated at the edge) and border flag out.
module bike_step
    import tron_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  pos_t head,
    input  dir_t dir,
    output pos_t next,
    output logic border
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

    // Off-grid steps raise border and leave the coordinate parked on the edge.
    always_comb begin
        next   = head;
        border = 1'b0;
        unique case (1'b1)
            (dir == UP): begin
                if (head.y == '0) border = 1'b1;
                else              next.y = head.y - 1'b1;
            end
            (dir == DOWN): begin
                if (head.y == Y_MAX) border = 1'b1;
                else                 next.y = head.y + 1'b1;
            end
            (dir == LEFT): begin
                if (head.x == '0) border = 1'b1;
                else              next.x = head.x - 1'b1;
            end
            (dir == RIGHT): begin
                if (head.x == X_MAX) border = 1'b1;
                else                 next.x = head.x + 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bike_motion.sv
// Light-cycle motion stage: steps both bikes, checks collisions, commits heads.
// Ports: clock/reset_n, tick/start, direction requests, occupancy lookup, heads/en_cond, game_over/winner.
module bike_motion
    import tron_pkg::*;
#(
    parameter int   GRID_W   = GRID_W_DEF,
    parameter int   GRID_H   = GRID_H_DEF,
    parameter int   STEP_DIV = 2,
    parameter int   P1_X     = 200,
    parameter int   P1_Y     = 300,
    parameter dir_t P1_DIR   = RIGHT,
    parameter int   P2_X     = 600,
    parameter int   P2_Y     = 300,
    parameter dir_t P2_DIR   = LEFT
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               start,
    input  logic [1:0]         p1_dir,
    input  logic [1:0]         p2_dir,
    input  logic               p1_dir_valid,
    input  logic               p2_dir_valid,
    output logic               occ_req,
    output logic [COORD_W-1:0] occ_x,
    output logic [COORD_W-1:0] occ_y,
    input  logic               occ_hit,
    output logic [COORD_W-1:0] new_x1,
    output logic [COORD_W-1:0] new_y1,
    output logic [COORD_W-1:0] new_x2,
    output logic [COORD_W-1:0] new_y2,
    output logic               en_cond,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam pos_t START1 = {COORD_W'(P1_X), COORD_W'(P1_Y)};
    localparam pos_t START2 = {COORD_W'(P2_X), COORD_W'(P2_Y)};
    localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

    state_t     state;
    logic [7:0] div;
    pos_t       head1, head2;
    pos_t       next1, next2;
    logic       border1, border2;
    logic       hit1, hit2;
    dir_t       pend1, pend2;
    dir_t       cmt1, cmt2;

    pos_t       s1_next, s2_next;
    logic       s1_border, s2_border;
    logic       restart;
    dir_t       cmt1_eff, cmt2_eff;
    logic       same, swap, crash1, crash2;

    assign new_x1 = head1.x;
    assign new_y1 = head1.y;
    assign new_x2 = head2.x;
    assign new_y2 = head2.y;

    assign restart = start && (state == IDLE || state == OVER);

    // Pending is what MOVE latches, so the step is computed from it directly.
    bike_step #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_step1 (
        .head   (head1),
        .dir    (pend1),
        .next   (s1_next),
        .border (s1_border)
    );

    bike_step #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_step2 (
        .head   (head2),
        .dir    (pend2),
        .next   (s2_next),
        .border (s2_border)
    );

    // During MOVE the pending direction is the one about to take effect, so a
    // request arriving then is screened against it rather than the stale one.
    assign cmt1_eff = (state == MOVE) ? pend1 : cmt1;
    assign cmt2_eff = (state == MOVE) ? pend2 : cmt2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend1 <= P1_DIR;
            pend2 <= P2_DIR;
            cmt1  <= P1_DIR;
            cmt2  <= P2_DIR;
        end else if (restart) begin
            pend1 <= P1_DIR;
            pend2 <= P2_DIR;
            cmt1  <= P1_DIR;
            cmt2  <= P2_DIR;
        end else begin
            if (state == MOVE) begin
                cmt1 <= pend1;
                cmt2 <= pend2;
            end
            if (p1_dir_valid && !is_reverse(p1_dir, cmt1_eff))
                pend1 <= dir_t'(p1_dir);
            if (p2_dir_valid && !is_reverse(p2_dir, cmt2_eff))
                pend2 <= dir_t'(p2_dir);
        end
    end

    always_comb begin
        same   = (next1 == next2);
        swap   = (next1 == head2) && (next2 == head1);
        crash1 = border1 | hit1 | same | swap;
        crash2 = border2 | hit2 | same | swap;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            div       <= '0;
            head1     <= START1;
            head2     <= START2;
            next1     <= '0;
            next2     <= '0;
            border1   <= 1'b0;
            border2   <= 1'b0;
            hit1      <= 1'b0;
            hit2      <= 1'b0;
            occ_req   <= 1'b0;
            occ_x     <= '0;
            occ_y     <= '0;
            en_cond   <= 1'b0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else begin
            en_cond <= 1'b0;
            occ_req <= 1'b0;
            unique case (state)
                IDLE, OVER: begin
                    if (start) begin
                        head1     <= START1;
                        head2     <= START2;
                        div       <= '0;
                        winner    <= WIN_NONE;
                        game_over <= 1'b0;
                        en_cond   <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (tick) begin
                        if (div == DIV_LAST) begin
                            div   <= '0;
                            state <= MOVE;
                        end else begin
                            div <= div + 8'd1;
                        end
                    end
                end
                MOVE: begin
                    next1   <= s1_next;
                    next2   <= s2_next;
                    border1 <= s1_border;
                    border2 <= s2_border;
                    occ_req <= 1'b1;
                    occ_x   <= s1_next.x;
                    occ_y   <= s1_next.y;
                    state   <= Q1;
                end
                Q1: begin
                    occ_req <= 1'b1;
                    occ_x   <= next2.x;
                    occ_y   <= next2.y;
                    state   <= Q2;
                end
                Q2: begin
                    hit1  <= occ_hit & ~border1;
                    state <= Q3;
                end
                Q3: begin
                    hit2  <= occ_hit & ~border2;
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    if (!crash1 && !crash2) begin
                        head1   <= next1;
                        head2   <= next2;
                        en_cond <= 1'b1;
                        state   <= WAIT;
                    end else begin
                        winner    <= {crash1, crash2};
                        game_over <= 1'b1;
                        state     <= OVER;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/bike_motion.md
# bike_motion

Game-logic stage that owns both light-cycle positions and feeds the trace renderer directly upstream of it. Once per move period it steps each bike one pixel in its latched direction. It checks the border, the occupancy grid and bike-vs-bike collisions, then either commits the new heads or declares game over. Committed heads and a one-cycle write strobe drive the renderer's `new_x1/new_y1/new_x2/new_y2/en_cond` inputs.

## Interface
- `GRID_W`, 800, playfield width in pixels; x range 0..GRID_W-1
- `GRID_H`, 600, playfield height; y range 0..GRID_H-1
- `STEP_DIV`, 2, frame ticks per move step (≥1)
- `P1_X`/`P1_Y`/`P1_DIR`, 200/300/RIGHT, bike 1 start
- `P2_X`/`P2_Y`/`P2_DIR`, 600/300/LEFT, bike 2 start
- `clock` in 1 — sole clock
- `reset_n` in 1 — asynchronous, active-low reset
- `tick` in 1 — one-cycle pulse per video frame
- `start` in 1 — begin/restart round (level sampled)
- `p1_dir`, `p2_dir` in 2 — requested direction: 00 up, 01 right, 10 down, 11 left
- `p1_dir_valid`, `p2_dir_valid` in 1 — request qualifier
- `occ_req` out 1 — occupancy lookup strobe
- `occ_x`, `occ_y` out 10 — lookup coordinate
- `occ_hit` in 1 — grid occupied (either trace); valid exactly one cycle after `occ_req`
- `new_x1`, `new_y1`, `new_x2`, `new_y2` out 10 — committed heads
- `en_cond` out 1 — one-cycle commit/write strobe
- `game_over` out 1 — round ended
- `winner` out 2 — 01 bike 1, 10 bike 2, 11 draw, 00 none

## Operation
- States: IDLE, WAIT, MOVE, Q1, Q2, Q3, RESOLVE, OVER.
- **IDLE**: heads at start positions.
  - `start`=1 → `en_cond` pulse with start heads, then WAIT.
- **WAIT**: each `tick` increments the 8-bit divider.
  - At STEP_DIV-1: clear the divider, go to MOVE.
  - `tick` in any other state is ignored and not counted.
- **MOVE**: latch pending directions into committed directions; compute `next1`/`next2`.
  - Stepping off-grid sets `border_n`; no wrap.
  - Next coordinate is saturated at the edge; it is not used for commit.
- **Q1**: `occ_req`=1, `occ_x/y`=`next1`.
- **Q2**: `occ_req`=1, `occ_x/y`=`next2`; sample `hit1`.
- **Q3**: `occ_req`=0; sample `hit2`.
  - A border-crashed bike's hit is forced 0 (address unused).
- **RESOLVE**:
  - `crashN = borderN | hitN | (next1==next2) | (next1==head2 && next2==head1)`.
  - No crash: heads←next, `en_cond` pulse, → WAIT.
  - Otherwise: → OVER with `winner` = {crash1, crash2} mapped 01 (only 2 crashed), 10 (only 1), 11 (both).
  - Heads are not updated on crash.
- **OVER**: `game_over`=1, `winner` held.
  - `start`=1 → reload start heads/directions, clear divider/`winner`/`game_over`, `en_cond` pulse, → WAIT.
- **Direction register**: in any state, a `pN_dir_valid` request updates `pendingN` unless it is the reverse of `committedN`.
  - Reverse means (dir ^ committed) == 2'b10; reverse requests are dropped.
  - A non-reverse, non-current request overrides an earlier pending one in the same period.
- `start` outside IDLE/OVER is ignored.

## Timing
- All outputs are registered.
- Reset values: heads = start params, `en_cond`/`occ_req`/`game_over` 0, `occ_x/y` 0, `winner` 00, state IDLE, divider 0, pending = committed = start directions.
- Qualifying `tick` sampled at cycle T: MOVE T+1, Q1 T+2, Q2 T+3, Q3 T+4, RESOLVE T+5.
  - Heads change and `en_cond`=1 at T+6, for exactly one cycle.
- Step period is at least 6 clocks, far below a frame, so no tick can arrive mid-step.
- `reset_n` deasserting mid-step aborts immediately: no `en_cond`, no `occ_req`.

## Structure
- `tron_pkg`:
  - `dir_t` (UP/RIGHT/DOWN/LEFT)
  - `state_t`
  - GRID_W/GRID_H defaults
  - `winner` encodings
- Sub-module `bike_step`: combinational head+dir → next head + border flag. Instantiated twice.
- Top module `bike_motion`: FSM, divider and direction registers (~200 lines).

## Test plan
- Reset, `start`, STEP_DIV=1, no hits → `en_cond` at first commit with (200,300)/(600,300); after the next tick, (201,300)/(599,300) at T+6.
- Bike 1 heading RIGHT requests LEFT then UP within one period → next step (x, 299); the LEFT request is ignored.
- Bike 1 at x=799 heading RIGHT → OVER, `winner`=10, heads unchanged, no `en_cond`.
- `occ_hit`=1 in the cycle after the Q2 lookup (the bike-2 lookup), else 0 → `winner`=01, `game_over`=1.
- Bikes at (400,300)/(402,300) moving toward each other → `next1==next2` (401,300) → `winner`=11.
- Assert `reset_n` low during Q2 → outputs at reset values immediately. `start` in OVER → restart with `en_cond` on start heads.
